// File: rtl/nn_layer_sequencer_if.sv
// Bus bundle between the layer sequencer, its layer engines and the shared SDRAM master.
// Layers are started by holding layer_ready high and answer with layer_done; a layer must
// drop layer_done again before the next layer is started. The Avalon side follows standard
// semantics: a transfer completes on a cycle where waitrequest is low, and read data is
// valid on cycles where readdatavalid is high.
interface nn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16
);
  logic [NUM_LAYERS-1:0]        layer_ready;
  logic [NUM_LAYERS-1:0]        layer_done;
  logic [NUM_LAYERS*ADDR_W-1:0] lyr_address;
  logic [NUM_LAYERS-1:0]        lyr_read_n;
  logic [NUM_LAYERS-1:0]        lyr_write_n;
  logic [NUM_LAYERS*DATA_W-1:0] lyr_writedata;
  logic [DATA_W-1:0]            lyr_readdata;
  logic [NUM_LAYERS-1:0]        lyr_waitrequest;
  logic [NUM_LAYERS-1:0]        lyr_readdatavalid;
  logic [ADDR_W-1:0]            m_address;
  logic                         m_read_n;
  logic                         m_write_n;
  logic [DATA_W-1:0]            m_writedata;
  logic [DATA_W-1:0]            m_readdata;
  logic                         m_waitrequest;
  logic                         m_readdatavalid;
  logic                         m_chipselect;
  logic [1:0]                   m_byteenable;

  modport master (
    output layer_ready, lyr_readdata, lyr_waitrequest, lyr_readdatavalid,
    output m_address, m_read_n, m_write_n, m_writedata, m_chipselect, m_byteenable,
    input  layer_done, lyr_address, lyr_read_n, lyr_write_n, lyr_writedata,
    input  m_readdata, m_waitrequest, m_readdatavalid
  );

  modport slave (
    input  layer_ready, lyr_readdata, lyr_waitrequest, lyr_readdatavalid,
    input  m_address, m_read_n, m_write_n, m_writedata, m_chipselect, m_byteenable,
    output layer_done, lyr_address, lyr_read_n, lyr_write_n, lyr_writedata,
    output m_readdata, m_waitrequest, m_readdatavalid
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Runs the layer engines one after another and grants the shared SDRAM master to the
// active layer only; reports busy/done/error, a busy-cycle counter and a hex status word.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int TIMEOUT    = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        all_done,
  output logic        error,
  output logic [1:0]  cur_layer,
  output logic [31:0] cycle_count,
  output logic [31:0] toHexLed,
  nn_layer_sequencer_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_RELEASE = 3'd2,
    S_FINISH  = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [1:0]              cur_layer_q;
  logic [NUM_LAYERS-1:0]   layer_ready_q;
  logic                    error_q;
  logic [31:0]             cycle_count_q;
  logic [WD_W-1:0]         wdog_q;
  logic                    grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_layer_q   <= '0;
      layer_ready_q <= '0;
      error_q       <= 1'b0;
      cycle_count_q <= '0;
      wdog_q        <= '0;
    end else begin
      // The edge that takes an abort leaves the counter untouched.
      if ((state_q == S_RUN || state_q == S_RELEASE) && !abort && cycle_count_q != '1)
        cycle_count_q <= cycle_count_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q       <= S_RUN;
            cur_layer_q   <= '0;
            cycle_count_q <= '0;
            error_q       <= 1'b0;
            wdog_q        <= '0;
            layer_ready_q <= NUM_LAYERS'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q       <= S_IDLE;
            layer_ready_q <= '0;
          end else if (bus.layer_done[cur_layer_q]) begin
            state_q       <= S_RELEASE;
            layer_ready_q <= '0;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            state_q       <= S_FAULT;
            layer_ready_q <= '0;
            error_q       <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_RELEASE: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (!bus.layer_done[cur_layer_q]) begin
            if (cur_layer_q == LAST_LAYER) begin
              state_q <= S_FINISH;
            end else begin
              state_q       <= S_RUN;
              cur_layer_q   <= cur_layer_q + 2'd1;
              wdog_q        <= '0;
              layer_ready_q <= NUM_LAYERS'(1) << (cur_layer_q + 2'd1);
            end
          end
        end
        S_FINISH: if (!start) state_q <= S_IDLE;
        S_FAULT:  if (!start) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Grant follows cur_layer, which only changes on the RELEASE->RUN edge.
  assign grant = (state_q == S_RUN) || (state_q == S_RELEASE);

  always_comb begin
    bus.m_address         = '0;
    bus.m_read_n          = 1'b1;
    bus.m_write_n         = 1'b1;
    bus.m_writedata       = '0;
    bus.lyr_waitrequest   = '1;
    bus.lyr_readdatavalid = '0;
    if (grant) begin
      bus.m_address   = bus.lyr_address[int'(cur_layer_q)*ADDR_W +: ADDR_W];
      bus.m_read_n    = bus.lyr_read_n[cur_layer_q];
      bus.m_write_n   = bus.lyr_write_n[cur_layer_q];
      bus.m_writedata = bus.lyr_writedata[int'(cur_layer_q)*DATA_W +: DATA_W];
      bus.lyr_waitrequest[cur_layer_q]   = bus.m_waitrequest;
      bus.lyr_readdatavalid[cur_layer_q] = bus.m_readdatavalid;
    end
  end

  assign bus.lyr_readdata = bus.m_readdata;
  assign bus.m_chipselect = 1'b1;
  assign bus.m_byteenable = 2'b11;
  assign bus.layer_ready  = layer_ready_q;

  assign busy        = grant;
  assign all_done    = (state_q == S_FINISH);
  assign error       = error_q;
  assign cur_layer   = cur_layer_q;
  assign cycle_count = cycle_count_q;
  assign toHexLed    = {23'h0, error_q, 4'(cur_layer_q), 4'(state_q)};

endmodule
